// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, FSM state type and geometry helpers for the instruction cache
package icache_pkg;

    localparam int ADDR_W     = 16;
    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_W     = LINE_WORDS * WORD_SIZE;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    function automatic int index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Two address bits select the word inside a 4-word line.
    function automatic int tag_w(input int num_lines);
        return ADDR_W - 2 - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// rtl/icache_line_store.sv - tag/valid/data arrays with async read, sync install and bulk valid clear
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = 3,
    parameter int TAG_W     = 11,
    parameter int LINE_BITS = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [INDEX_W-1:0]   rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [INDEX_W-1:0]   wr_index,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 clear
);

    logic [NUM_LINES-1:0] valid_r;
    logic [TAG_W-1:0]     tag_r  [NUM_LINES];
    logic [LINE_BITS-1:0] line_r [NUM_LINES];

    // An install in the same cycle as a clear survives: the line just fetched is fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_r <= '0;
        end else begin
            if (clear) begin
                valid_r <= '0;
            end
            if (wr_en) begin
                valid_r[wr_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_index]  <= wr_tag;
            line_r[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_line  = line_r[rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// rtl/icache_direct_mapped.sv - direct-mapped read-only instruction cache; ICACHE_STATS_EN adds hit/miss counters
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int WORD_SIZE = 16
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            i_readM,
    input  logic [15:0]                     i_address,
    output logic [WORD_SIZE-1:0]            i_data,
    output logic                            i_ready,
    input  logic                            flush,
    output logic                            mem_readM,
    output logic [15:0]                     mem_address,
    input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_data,
    input  logic                            mem_read_ack
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]                     hit_count,
    output logic [15:0]                     miss_count
`endif
);

    localparam int INDEX_W   = index_w(NUM_LINES);
    localparam int TAG_W     = tag_w(NUM_LINES);
    localparam int LINE_BITS = LINE_WORDS * WORD_SIZE;

    logic [INDEX_W-1:0]   req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [1:0]           req_offset;
    logic [INDEX_W-1:0]   fill_index;
    logic [TAG_W-1:0]     fill_tag;

    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_line;

    state_t               state_r;
    state_t               state_n;
    logic                 mem_readM_n;
    logic [15:0]          mem_address_n;
    logic                 seen_low_r;
    logic                 seen_low_n;
    logic                 install;
    logic                 hit;
    logic [WORD_SIZE-1:0] sel_word;

    assign req_offset = i_address[1:0];
    assign req_index  = i_address[2 +: INDEX_W];
    assign req_tag    = i_address[15 -: TAG_W];

    // Fills target the latched line, so a CPU address change mid-fetch cannot redirect them.
    assign fill_index = mem_address[2 +: INDEX_W];
    assign fill_tag   = mem_address[15 -: TAG_W];

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W),
        .LINE_BITS (LINE_BITS)
    ) u_line_store (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_index (req_index),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (install),
        .wr_index (fill_index),
        .wr_tag   (fill_tag),
        .wr_line  (mem_data),
        .clear    (flush)
    );

    assign hit = i_readM && rd_valid && (rd_tag == req_tag) && (state_r == IDLE) && !flush;

    // Word 0 sits in the most significant slice of the line.
    always_comb begin
        sel_word = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (req_offset == 2'(w)) begin
                sel_word = rd_line[(LINE_WORDS-1-w)*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    assign i_ready = hit;
    assign i_data  = hit ? sel_word : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            mem_readM   <= 1'b0;
            mem_address <= '0;
            seen_low_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            mem_readM   <= mem_readM_n;
            mem_address <= mem_address_n;
            seen_low_r  <= seen_low_n;
        end
    end

    // An ack only counts after the memory has been seen low during this fetch.
    always_comb begin
        state_n       = state_r;
        mem_readM_n   = mem_readM;
        mem_address_n = mem_address;
        seen_low_n    = seen_low_r;
        install       = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_readM && !hit && !flush) begin
                    mem_address_n = {i_address[15:2], 2'b00};
                    mem_readM_n   = 1'b1;
                    seen_low_n    = 1'b0;
                    state_n       = FETCH;
                end
            end
            FETCH: begin
                mem_readM_n = 1'b1;
                if (!mem_read_ack) begin
                    seen_low_n = 1'b1;
                end else if (seen_low_r) begin
                    install     = 1'b1;
                    mem_readM_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n     = IDLE;
                mem_readM_n = 1'b0;
            end
        endcase
    end

`ifdef ICACHE_STATS_EN
    logic fetch_start;
    assign fetch_start = (state_r == IDLE) && (state_n == FETCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (i_ready && hit_count != 16'hffff) begin
                hit_count <= hit_count + 16'd1;
            end
            if (fetch_start && miss_count != 16'hffff) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct_mapped.sv
// tb/tb_icache_direct_mapped.sv - randomized self-checking bench for icache_direct_mapped (ICACHE_STATS_EN optional)
module tb_icache_direct_mapped;

    localparam int NL = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        i_readM = 1'b0;
    logic [15:0] i_address = '0;
    logic [15:0] i_data;
    logic        i_ready;
    logic        flush = 1'b0;
    logic        mem_readM;
    logic [15:0] mem_address;
    logic [63:0] mem_data = '0;
    logic        mem_read_ack = 1'b0;
`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int tests = 0;
    int fails = 0;
    int cached_line [NL];
    int lat = 2;
    bit resp_en = 1'b1;
    int resp_cnt = 0;
    int fills = 0;
    logic prev_rd = 1'b0;

    icache_direct_mapped #(.NUM_LINES(NL), .WORD_SIZE(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_readM      (i_readM),
        .i_address    (i_address),
        .i_data       (i_data),
        .i_ready      (i_ready),
        .flush        (flush),
        .mem_readM    (mem_readM),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_read_ack (mem_read_ack)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count    (hit_count),
        .miss_count   (miss_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] line_of(input logic [15:0] la);
        if (la == 16'h0024) return 64'h6100_f41c_6200_f81c;
        return {la ^ 16'ha5a5, la + 16'h1234, ~la, la[7:0], la[15:8]};
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [63:0] l;
        l = line_of({a[15:2], 2'b00});
        return l[(3 - a[1:0]) * 16 +: 16];
    endfunction

    task automatic clear_model;
        for (int i = 0; i < NL; i++) cached_line[i] = -1;
    endtask

    // Memory: keeps ack low for lat-1 cycles of a request, then presents the line.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (mem_readM === 1'b1 && prev_rd !== 1'b1) fills++;
            prev_rd = mem_readM;
            if (resp_en) begin
                if (mem_readM === 1'b1) begin
                    resp_cnt++;
                    if (resp_cnt >= lat) begin
                        mem_read_ack = 1'b1;
                        mem_data = line_of(mem_address);
                    end
                end else begin
                    resp_cnt = 0;
                    mem_read_ack = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic fetch(input logic [15:0] a);
        logic exp_hit;
        logic [15:0] exp_w;
        logic [15:0] al;
        int f0;
        int cyc;
        al = {a[15:2], 2'b00};
        exp_hit = (cached_line[a[4:2]] == int'(al));
        exp_w = word_of(a);
        i_address = a;
        i_readM = 1'b1;
        #1;
        tests++;
        if (i_ready !== exp_hit) begin
            fails++;
            $display("FAIL lookup %h: i_ready=%b required %b", a, i_ready, exp_hit);
        end
        if (exp_hit) begin
            tests++;
            if (i_data !== exp_w) begin
                fails++;
                $display("FAIL hit_data %h: got %h required %h", a, i_data, exp_w);
            end
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (mem_readM !== 1'b0) begin
                fails++;
                $display("FAIL hit_no_mem %h: mem_readM=%b required 0", a, mem_readM);
            end
        end else begin
            f0 = fills;
            @(negedge clk);
            #1;
            tests++;
            if (mem_readM !== 1'b1 || mem_address !== al) begin
                fails++;
                $display("FAIL miss_req %h: mem_readM=%b mem_address=%h required 1/%h", a, mem_readM, mem_address, al);
            end
            cyc = 0;
            while (i_ready !== 1'b1 && cyc < 40) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            tests++;
            if (i_ready !== 1'b1) begin
                fails++;
                $display("FAIL fill_timeout %h: i_ready=%b required 1", a, i_ready);
            end else if (i_data !== exp_w) begin
                fails++;
                $display("FAIL fill_data %h: got %h required %h", a, i_data, exp_w);
            end
            tests++;
            if (fills != f0 + 1) begin
                fails++;
                $display("FAIL fill_count %h: got %0d required %0d", a, fills - f0, 1);
            end
            cached_line[a[4:2]] = int'(al);
            @(posedge clk);
            @(negedge clk);
        end
        i_readM = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        i_readM = 1'b0;
        flush = 1'b0;
        reset_n = 1'b0;
        #1;
        tests++;
        if (i_ready !== 1'b0 || i_data !== 16'h0 || mem_readM !== 1'b0 || mem_address !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: ready=%b data=%h readM=%b addr=%h required 0/0000/0/0000",
                     i_ready, i_data, mem_readM, mem_address);
        end
`ifdef ICACHE_STATS_EN
        tests++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_counters: hit=%0d miss=%0d required 0/0", hit_count, miss_count);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
    endtask

    task automatic test_cold_miss;
        lat = 2;
        fetch(16'h0024);
    endtask

    task automatic test_same_line;
        fetch(16'h0027);
        fetch(16'h0025);
    endtask

    task automatic test_conflict;
        fetch(16'h0044);
        fetch(16'h0024);
        fetch(16'h0044);
    endtask

    task automatic test_stale_ack;
        resp_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        i_readM = 1'b0;
        mem_read_ack = 1'b1;
        mem_data = 64'hdead_beef_0bad_cafe;
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
        i_address = 16'h0010;
        i_readM = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        tests++;
        if (mem_readM !== 1'b1 || i_ready !== 1'b0) begin
            fails++;
            $display("FAIL stale_ignored: readM=%b ready=%b required 1/0", mem_readM, i_ready);
        end
        mem_read_ack = 1'b0;
        @(negedge clk);
        mem_read_ack = 1'b1;
        mem_data = line_of(16'h0010);
        @(negedge clk);
        mem_read_ack = 1'b0;
        #1;
        tests++;
        if (i_ready !== 1'b1 || i_data !== word_of(16'h0010) || mem_readM !== 1'b0) begin
            fails++;
            $display("FAIL stale_install: ready=%b data=%h readM=%b required 1/%h/0",
                     i_ready, i_data, mem_readM, word_of(16'h0010));
        end
        cached_line[4] = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        i_readM = 1'b0;
        resp_en = 1'b1;
    endtask

    task automatic test_flush_fetch;
        int cyc;
        lat = 4;
        fetch(16'h0024);
        i_address = 16'h0030;
        i_readM = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
        cyc = 0;
        #1;
        while (i_ready !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        tests++;
        if (i_ready !== 1'b1 || i_data !== word_of(16'h0030)) begin
            fails++;
            $display("FAIL flush_fetch_install: ready=%b data=%h required 1/%h", i_ready, i_data, word_of(16'h0030));
        end
        cached_line[4] = 16'h0030;
        @(posedge clk);
        @(negedge clk);
        i_readM = 1'b0;
        lat = 2;
        fetch(16'h0031);
        fetch(16'h0024);
    endtask

    task automatic test_flush_idle;
        fetch(16'h0026);
        i_address = 16'h0026;
        i_readM = 1'b1;
        flush = 1'b1;
        #1;
        tests++;
        if (i_ready !== 1'b0 || i_data !== 16'h0) begin
            fails++;
            $display("FAIL flush_idle_ready: ready=%b data=%h required 0/0000", i_ready, i_data);
        end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        i_readM = 1'b0;
        #1;
        tests++;
        if (mem_readM !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_nofetch: mem_readM=%b required 0", mem_readM);
        end
        clear_model();
        fetch(16'h0026);
    endtask

    task automatic test_addr_change;
        int cyc;
        i_address = 16'h0050;
        i_readM = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (mem_address !== 16'h0050) begin
            fails++;
            $display("FAIL addr_change_latch: mem_address=%h required 0050", mem_address);
        end
        i_address = 16'h0060;
        cyc = 0;
        while (mem_readM === 1'b1 && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        cached_line[4] = 16'h0050;
        tests++;
        if (mem_readM !== 1'b0 || i_ready !== (cached_line[0] == 16'h0060)) begin
            fails++;
            $display("FAIL addr_change_done: readM=%b ready=%b required 0/%b",
                     mem_readM, i_ready, (cached_line[0] == 16'h0060));
        end
        i_readM = 1'b0;
        @(negedge clk);
        fetch(16'h0053);
        fetch(16'h0060);
    endtask

    task automatic test_reset_mid_fetch;
        i_address = 16'h007c;
        i_readM = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        tests++;
        if (mem_readM !== 1'b0 || mem_address !== 16'h0 || i_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_fetch: readM=%b addr=%h ready=%b required 0/0000/0", mem_readM, mem_address, i_ready);
        end
`ifdef ICACHE_STATS_EN
        tests++;
        if (hit_count !== 16'h0 || miss_count !== 16'h0) begin
            fails++;
            $display("FAIL reset_mid_counters: hit=%0d miss=%0d required 0/0", hit_count, miss_count);
        end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        i_readM = 1'b0;
        clear_model();
        fetch(16'h0024);
        fetch(16'h0025);
        fetch(16'h0026);
`ifdef ICACHE_STATS_EN
        tests++;
        if (hit_count !== 16'd3 || miss_count !== 16'd1) begin
            fails++;
            $display("FAIL stats_after_reset: hit=%0d miss=%0d required 3/1", hit_count, miss_count);
        end
`endif
    endtask

    task automatic test_random;
        logic [15:0] a;
        for (int n = 0; n < 60; n++) begin
            a = 16'($urandom_range(0, 127));
            lat = $urandom_range(2, 5);
            if ($urandom_range(0, 9) == 0) begin
                flush = 1'b1;
                @(negedge clk);
                flush = 1'b0;
                clear_model();
            end
            fetch(a);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin : main
        clear_model();
        test_reset();
        test_cold_miss();
        test_same_line();
        test_conflict();
        test_stale_ack();
        test_flush_fetch();
        test_flush_idle();
        test_addr_change();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
